// File: rtl/pcie_reg_arbiter_pkg.sv
// Shared definitions for the PCIe register-file arbiter.
//   ADDR_WIDTH / DATA_WIDTH : register index and data widths (16 x 32-bit file)
//   state_e                 : arbiter FSM states
//   REQ_H / REQ_F           : requester ids (host TLP decoder / FPGA fabric)
package pcie_reg_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_e;

  localparam logic REQ_H = 1'b0;
  localparam logic REQ_F = 1'b1;

endpackage

// File: rtl/pcie_reg_arbiter_if.sv
// Bundle of every handshake and register-file signal around the arbiter.
//   h_* : host requester (PCIe BAR0 decoder) request/response channels
//   f_* : FPGA-internal requester request/response channels
//   rf_*: single-ported register file access port
// Handshake rule for all channels: a transfer happens on a rising clock edge
// where valid and ready are both high; the source holds valid and all
// payload fields stable until that edge, and payload is ignored while
// valid is low.
// modport slave  : arbiter side
// modport master : environment side (requesters + register file)
interface pcie_reg_arbiter_if;
  import pcie_reg_pkg::*;

  logic                  h_req_valid;
  logic                  h_req_ready;
  logic                  h_req_write;
  logic [ADDR_WIDTH-1:0] h_req_addr;
  logic [DATA_WIDTH-1:0] h_req_wdata;
  logic                  h_rsp_valid;
  logic                  h_rsp_ready;
  logic [DATA_WIDTH-1:0] h_rsp_data;

  logic                  f_req_valid;
  logic                  f_req_ready;
  logic                  f_req_write;
  logic [ADDR_WIDTH-1:0] f_req_addr;
  logic [DATA_WIDTH-1:0] f_req_wdata;
  logic                  f_rsp_valid;
  logic                  f_rsp_ready;
  logic [DATA_WIDTH-1:0] f_rsp_data;

  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [DATA_WIDTH-1:0] rf_rdata;

  modport slave (
    input  h_req_valid, h_req_write, h_req_addr, h_req_wdata, h_rsp_ready,
    input  f_req_valid, f_req_write, f_req_addr, f_req_wdata, f_rsp_ready,
    input  rf_rdata,
    output h_req_ready, h_rsp_valid, h_rsp_data,
    output f_req_ready, f_rsp_valid, f_rsp_data,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wdata
  );

  modport master (
    output h_req_valid, h_req_write, h_req_addr, h_req_wdata, h_rsp_ready,
    output f_req_valid, f_req_write, f_req_addr, f_req_wdata, f_rsp_ready,
    output rf_rdata,
    input  h_req_ready, h_rsp_valid, h_rsp_data,
    input  f_req_ready, f_rsp_valid, f_rsp_data,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wdata
  );

endinterface

// File: rtl/pcie_reg_arbiter_rr_arb2.sv
// Two-input round-robin picker (purely combinational).
//   valid_h, valid_f : request valids from H and F
//   last_grant       : id of the side granted most recently (registered by parent)
//   grant            : one-hot grant, bit 0 = H, bit 1 = F; zero when nobody asks
//   winner           : id of the granted side (REQ_H when nobody asks)
module rr_arb2
  import pcie_reg_pkg::*;
(
  input  logic       valid_h,
  input  logic       valid_f,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    grant  = 2'b00;
    winner = REQ_H;
    // H wins when alone, or on a tie when F was served last.
    if (valid_h && (!valid_f || (last_grant == REQ_F))) begin
      grant  = 2'b01;
      winner = REQ_H;
    end else if (valid_f) begin
      grant  = 2'b10;
      winner = REQ_F;
    end
  end

endmodule

// File: rtl/pcie_reg_arbiter.sv
// Round-robin arbiter sharing a single-ported register file between the
// host BAR0 decoder (H) and FPGA-internal logic (F).
//   clk_in         : clock
//   rstn           : asynchronous active-low reset (deassertion synchronised here)
//   bus            : request/response channels for H and F plus the rf_* port
//   dbg_state      : current FSM state
//   dbg_last_grant : side granted most recently (REQ_H / REQ_F)
// Writes complete in the grant cycle; reads go IDLE -> RD_WAIT -> RSP and
// hold the bus until the issuing side accepts its response.
module pcie_reg_arbiter
  import pcie_reg_pkg::*;
(
  input  logic              clk_in,
  input  logic              rstn,
  pcie_reg_arbiter_if.slave bus,
  output state_e            dbg_state,
  output logic              dbg_last_grant
);

  // Reset synchroniser: rstn clears everything at once, but the arbiter
  // only starts granting two clocks after rstn rises, so no strobe can be
  // raised by a half-released reset.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       run;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= rst_sync_d;
  end

  assign run = rst_sync_q[1];

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rd_id_q, rd_id_d;
  logic                  h_rsp_valid_q, h_rsp_valid_d;
  logic                  f_rsp_valid_q, f_rsp_valid_d;
  logic [DATA_WIDTH-1:0] h_rsp_data_q, h_rsp_data_d;
  logic [DATA_WIDTH-1:0] f_rsp_data_q, f_rsp_data_d;

  // Requests only compete while idle and out of reset.
  logic       arb_valid_h, arb_valid_f;
  logic [1:0] grant;
  logic       winner;

  assign arb_valid_h = run && (state_q == IDLE) && bus.h_req_valid;
  assign arb_valid_f = run && (state_q == IDLE) && bus.f_req_valid;

  rr_arb2 u_rr_arb2 (
    .valid_h    (arb_valid_h),
    .valid_f    (arb_valid_f),
    .last_grant (last_grant_q),
    .grant      (grant),
    .winner     (winner)
  );

  logic                  h_req_ready, f_req_ready;
  logic                  rf_wr_en, rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  sel_write;
  logic                  sel_rsp_ready;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    rd_id_d       = rd_id_q;
    h_rsp_valid_d = h_rsp_valid_q;
    f_rsp_valid_d = f_rsp_valid_q;
    h_rsp_data_d  = h_rsp_data_q;
    f_rsp_data_d  = f_rsp_data_q;
    h_req_ready   = 1'b0;
    f_req_ready   = 1'b0;
    rf_wr_en      = 1'b0;
    rf_rd_en      = 1'b0;
    rf_addr       = '0;
    rf_wdata      = '0;
    sel_write     = 1'b0;
    sel_rsp_ready = (rd_id_q == REQ_H) ? bus.h_rsp_ready : bus.f_rsp_ready;

    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          last_grant_d = winner;
          if (winner == REQ_H) begin
            h_req_ready = 1'b1;
            sel_write   = bus.h_req_write;
            rf_addr     = bus.h_req_addr;
            rf_wdata    = bus.h_req_wdata;
          end else begin
            f_req_ready = 1'b1;
            sel_write   = bus.f_req_write;
            rf_addr     = bus.f_req_addr;
            rf_wdata    = bus.f_req_wdata;
          end
          if (sel_write) begin
            rf_wr_en = 1'b1;
          end else begin
            rf_rd_en = 1'b1;
            rd_id_d  = winner;
            state_d  = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // rf_rdata is valid exactly now, one cycle after rf_rd_en.
        if (rd_id_q == REQ_H) begin
          h_rsp_data_d  = bus.rf_rdata;
          h_rsp_valid_d = 1'b1;
        end else begin
          f_rsp_data_d  = bus.rf_rdata;
          f_rsp_valid_d = 1'b1;
        end
        state_d = RSP;
      end

      RSP: begin
        // Data register is left untouched so it keeps the last read value.
        if (sel_rsp_ready) begin
          h_rsp_valid_d = 1'b0;
          f_rsp_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_F;
      rd_id_q       <= REQ_H;
      h_rsp_valid_q <= 1'b0;
      f_rsp_valid_q <= 1'b0;
      h_rsp_data_q  <= '0;
      f_rsp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      rd_id_q       <= rd_id_d;
      h_rsp_valid_q <= h_rsp_valid_d;
      f_rsp_valid_q <= f_rsp_valid_d;
      h_rsp_data_q  <= h_rsp_data_d;
      f_rsp_data_q  <= f_rsp_data_d;
    end
  end

  assign bus.h_req_ready = h_req_ready;
  assign bus.f_req_ready = f_req_ready;
  assign bus.h_rsp_valid = h_rsp_valid_q;
  assign bus.f_rsp_valid = f_rsp_valid_q;
  assign bus.h_rsp_data  = h_rsp_data_q;
  assign bus.f_rsp_data  = f_rsp_data_q;
  assign bus.rf_wr_en    = rf_wr_en;
  assign bus.rf_rd_en    = rf_rd_en;
  assign bus.rf_addr     = rf_addr;
  assign bus.rf_wdata    = rf_wdata;

  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;

endmodule
